// File: rtl/sba_pkg.sv
// sba_pkg: shared types and constants for the System Bus Access sequencer.
// Contents: DMI register addresses, sbcs bit positions, sberror codes, FSM states,
//           plus alignment and read-data sizing helpers used by sba_ctrl.
package sba_pkg;

  // DMI register addresses owned by the SBA block.
  typedef enum logic [6:0] {
    DMI_SBCS        = 7'h38,
    DMI_SBADDRESS0  = 7'h39,
    DMI_SBADDRESS1  = 7'h3A,
    DMI_SBADDRESS2  = 7'h3B,
    DMI_SBDATA0     = 7'h3C,
    DMI_SBDATA1     = 7'h3D
  } sba_dmi_addr_e;

  // sbcs bit positions.
  localparam int SBCS_VERSION_LSB = 29;
  localparam int SBCS_BUSYERROR   = 22;
  localparam int SBCS_BUSY        = 21;
  localparam int SBCS_READONADDR  = 20;
  localparam int SBCS_ACCESS_LSB  = 17;
  localparam int SBCS_AUTOINC     = 16;
  localparam int SBCS_READONDATA  = 15;
  localparam int SBCS_ERROR_LSB   = 12;
  localparam int SBCS_ASIZE_LSB   = 5;

  typedef enum logic [2:0] {
    SBERR_NONE    = 3'd0,
    SBERR_TIMEOUT = 3'd1,
    SBERR_BADADDR = 3'd2,
    SBERR_ALIGN   = 3'd3,
    SBERR_SIZE    = 3'd4
  } sberror_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } sba_state_e;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic sba_misaligned(input logic [2:0] addr_lo, input logic [1:0] acc);
    logic bad;
    case (acc)
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr_lo[0];
      2'd2:    bad = |addr_lo[1:0];
      default: bad = |addr_lo[2:0];
    endcase
    return bad;
  endfunction

  // Keep only the low 2^acc bytes of engine read data, zero-extended to 64 bits.
  function automatic logic [63:0] sba_size_extend(input logic [63:0] d, input logic [1:0] acc);
    logic [63:0] r;
    case (acc)
      2'd0:    r = {56'd0, d[7:0]};
      2'd1:    r = {48'd0, d[15:0]};
      2'd2:    r = {32'd0, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sba_ctrl.sv
// sba_ctrl: debug-module SBA sequencer; owns sbcs/sbaddress/sbdata, launches single-beat engine accesses.
// Latency: start pulse in the cycle after the trigger; back in IDLE 3 cycles after trigger if ready follows the pulse.
// Backpressure: DMI data/address accesses while busy are dropped and raise sbbusyerror; WAIT is bounded by TIMEOUT.
// Ports: CLK/RST; DMI strobes sbcs_wr, sbaddr0/1_wr, sbdata0/1_wr, sbdata0_rd with dmi_wdata;
//        readback sbcs/sbaddress/sbdata; engine side sb_access, start_single_read/write,
//        read_data_ready, write_data_ready, sbdata_read, bus_error.
module sba_ctrl
  import sba_pkg::*;
#(
  parameter int SBASIZE = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               sbcs_wr,
  input  logic               sbaddr0_wr,
  input  logic               sbaddr1_wr,
  input  logic               sbdata0_wr,
  input  logic               sbdata1_wr,
  input  logic               sbdata0_rd,
  input  logic [31:0]        dmi_wdata,
  output logic [31:0]        sbcs,
  output logic [SBASIZE-1:0] sbaddress,
  output logic [63:0]        sbdata,
  output logic [2:0]         sb_access,
  output logic               start_single_read,
  output logic               start_single_write,
  input  logic               read_data_ready,
  input  logic               write_data_ready,
  input  logic [63:0]        sbdata_read,
  input  logic               bus_error
);

  // Counter only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  sba_state_e         state_q, state_d;
  logic               busyerr_q, busyerr_d;
  logic               readonaddr_q, readonaddr_d;
  logic [2:0]         sbaccess_q, sbaccess_d;
  logic               autoinc_q, autoinc_d;
  logic               readondata_q, readondata_d;
  logic [2:0]         sberror_q, sberror_d;
  logic [SBASIZE-1:0] sbaddress_q, sbaddress_d;
  logic [63:0]        sbdata_q, sbdata_d;
  logic [1:0]         acc_q, acc_d;     // size of the access in flight
  logic [TW-1:0]      cnt_q, cnt_d;
  logic               start_rd_q, start_rd_d;
  logic               start_wr_q, start_wr_d;

  logic               busy;
  logic               dmi_touch;
  logic               trig_rd;
  logic               trig_wr;
  logic               done;
  logic [63:0]        addr_ext;

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    busyerr_d    = busyerr_q;
    readonaddr_d = readonaddr_q;
    sbaccess_d   = sbaccess_q;
    autoinc_d    = autoinc_q;
    readondata_d = readondata_q;
    sberror_d    = sberror_q;
    sbdata_d     = sbdata_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    start_rd_d   = 1'b0;
    start_wr_d   = 1'b0;
    trig_rd      = 1'b0;
    trig_wr      = 1'b0;
    done         = 1'b0;
    addr_ext     = '0;
    addr_ext[SBASIZE-1:0] = sbaddress_q;

    // sbcs writes are accepted even while busy; the in-flight size is held in acc_q.
    if (sbcs_wr) begin
      readonaddr_d = dmi_wdata[SBCS_READONADDR];
      sbaccess_d   = dmi_wdata[SBCS_ACCESS_LSB +: 3];
      autoinc_d    = dmi_wdata[SBCS_AUTOINC];
      readondata_d = dmi_wdata[SBCS_READONDATA];
      if (dmi_wdata[SBCS_BUSYERROR]) busyerr_d = 1'b0;
      sberror_d = sberror_q & ~dmi_wdata[SBCS_ERROR_LSB +: 3];
    end

    dmi_touch = sbaddr0_wr | sbaddr1_wr | sbdata0_wr | sbdata1_wr | sbdata0_rd;

    if (busy) begin
      if (dmi_touch) busyerr_d = 1'b1;
    end else begin
      // Register loads happen first so a trigger sees the freshly written address/data.
      if (sbaddr0_wr) addr_ext[31:0]  = dmi_wdata;
      if (sbaddr1_wr) addr_ext[63:32] = dmi_wdata;
      if (sbdata0_wr) sbdata_d[31:0]  = dmi_wdata;
      if (sbdata1_wr) sbdata_d[63:32] = dmi_wdata;

      trig_rd = (sbaddr0_wr && readonaddr_q) || (sbdata0_rd && readondata_q);
      trig_wr = sbdata0_wr;

      if ((trig_rd || trig_wr) && (sberror_q == 3'd0) && !busyerr_q) begin
        if (sbaccess_q > 3'd3) begin
          sberror_d = SBERR_SIZE;
        end else if (sba_misaligned(addr_ext[2:0], sbaccess_q[1:0])) begin
          sberror_d = SBERR_ALIGN;
        end else begin
          acc_d = sbaccess_q[1:0];
          if (trig_wr) begin
            state_d    = ST_WR_REQ;
            start_wr_d = 1'b1;
          end else begin
            state_d    = ST_RD_REQ;
            start_rd_d = 1'b1;
          end
        end
      end
    end

    case (state_q)
      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
        cnt_d   = '0;
      end
      ST_WR_REQ: begin
        state_d = ST_WR_WAIT;
        cnt_d   = '0;
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        done = (state_q == ST_RD_WAIT) ? read_data_ready : write_data_ready;
        if (done) begin
          state_d = ST_IDLE;
          // Completion status overrides any error clear written in the same cycle.
          if (bus_error) begin
            sberror_d = SBERR_BADADDR;
          end else begin
            if (state_q == ST_RD_WAIT) sbdata_d = sba_size_extend(sbdata_read, acc_q);
            if (autoinc_q) addr_ext = addr_ext + (64'd1 << acc_q);
          end
        end else if ((TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT - 1))) begin
          state_d   = ST_IDLE;
          sberror_d = SBERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: ;
    endcase

    // Truncation gives the modulo-2^SBASIZE wrap for autoincrement.
    sbaddress_d = addr_ext[SBASIZE-1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      busyerr_q    <= 1'b0;
      readonaddr_q <= 1'b0;
      sbaccess_q   <= 3'd2;
      autoinc_q    <= 1'b0;
      readondata_q <= 1'b0;
      sberror_q    <= 3'd0;
      sbaddress_q  <= '0;
      sbdata_q     <= '0;
      acc_q        <= 2'd2;
      cnt_q        <= '0;
      start_rd_q   <= 1'b0;
      start_wr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busyerr_q    <= busyerr_d;
      readonaddr_q <= readonaddr_d;
      sbaccess_q   <= sbaccess_d;
      autoinc_q    <= autoinc_d;
      readondata_q <= readondata_d;
      sberror_q    <= sberror_d;
      sbaddress_q  <= sbaddress_d;
      sbdata_q     <= sbdata_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      start_rd_q   <= start_rd_d;
      start_wr_q   <= start_wr_d;
    end
  end

  always_comb begin
    sbcs = '0;
    sbcs[SBCS_VERSION_LSB +: 3] = 3'd1;
    sbcs[SBCS_BUSYERROR]        = busyerr_q;
    sbcs[SBCS_BUSY]             = busy;
    sbcs[SBCS_READONADDR]       = readonaddr_q;
    sbcs[SBCS_ACCESS_LSB +: 3]  = sbaccess_q;
    sbcs[SBCS_AUTOINC]          = autoinc_q;
    sbcs[SBCS_READONDATA]       = readondata_q;
    sbcs[SBCS_ERROR_LSB +: 3]   = sberror_q;
    sbcs[SBCS_ASIZE_LSB +: 7]   = 7'(SBASIZE);
    sbcs[4:0]                   = 5'b01111;
  end

  assign sbaddress          = sbaddress_q;
  assign sbdata             = sbdata_q;
  // While an access is in flight the engine keeps the size it was launched with.
  assign sb_access          = busy ? {1'b0, acc_q} : sbaccess_q;
  assign start_single_read  = start_rd_q;
  assign start_single_write = start_wr_q;

endmodule

// File: tb/tb_sba_ctrl.sv
// tb_sba_ctrl: directed table-driven bench for sba_ctrl with hand-written multi-cycle sequences.
// Latency: one table row per clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: engine readies are driven explicitly by the vectors; no flow control in the bench.
module tb_sba_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        sbcs_wr, sbaddr0_wr, sbaddr1_wr, sbdata0_wr, sbdata1_wr, sbdata0_rd;
  logic [31:0] dmi_wdata;
  logic [31:0] sbcs;
  logic [63:0] sbaddress;
  logic [63:0] sbdata;
  logic [2:0]  sb_access;
  logic        start_single_read, start_single_write;
  logic        read_data_ready, write_data_ready, bus_error;
  logic [63:0] sbdata_read;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [8:0] C_CS = 9'h001, C_A0 = 9'h002, C_D0 = 9'h004, C_RD = 9'h008,
                         C_RR = 9'h010, C_WR = 9'h020, C_BE = 9'h040, C_A1 = 9'h080,
                         C_D1 = 9'h100;

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] wd;
    logic [63:0] rd;
    logic [31:0] e_sbcs;
    logic [1:0]  e_pulse;   // {start_single_read, start_single_write}
    logic [63:0] e_addr;
    logic [63:0] e_data;
  } vec_t;

  vec_t vq[$];

  sba_ctrl #(.SBASIZE(64), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .sbcs_wr(sbcs_wr), .sbaddr0_wr(sbaddr0_wr), .sbaddr1_wr(sbaddr1_wr),
    .sbdata0_wr(sbdata0_wr), .sbdata1_wr(sbdata1_wr), .sbdata0_rd(sbdata0_rd),
    .dmi_wdata(dmi_wdata), .sbcs(sbcs), .sbaddress(sbaddress), .sbdata(sbdata),
    .sb_access(sb_access), .start_single_read(start_single_read),
    .start_single_write(start_single_write), .read_data_ready(read_data_ready),
    .write_data_ready(write_data_ready), .sbdata_read(sbdata_read), .bus_error(bus_error)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mkv(input logic [8:0] c, input logic [31:0] wd, input logic [63:0] rd,
                               input logic [31:0] es, input logic [1:0] ep,
                               input logic [63:0] ea, input logic [63:0] ed);
    vec_t v;
    v.ctl = c; v.wd = wd; v.rd = rd; v.e_sbcs = es; v.e_pulse = ep; v.e_addr = ea; v.e_data = ed;
    return v;
  endfunction

  task automatic clear_inputs();
    sbcs_wr = 1'b0; sbaddr0_wr = 1'b0; sbaddr1_wr = 1'b0; sbdata0_wr = 1'b0;
    sbdata1_wr = 1'b0; sbdata0_rd = 1'b0; read_data_ready = 1'b0;
    write_data_ready = 1'b0; bus_error = 1'b0; dmi_wdata = '0; sbdata_read = '0;
  endtask

  // Drive one cycle of stimulus, clock it in, sample 1 unit after the edge.
  task automatic drive(input logic [8:0] c, input logic [31:0] wd, input logic [63:0] rd);
    sbcs_wr = c[0]; sbaddr0_wr = c[1]; sbdata0_wr = c[2]; sbdata0_rd = c[3];
    read_data_ready = c[4]; write_data_ready = c[5]; bus_error = c[6];
    sbaddr1_wr = c[7]; sbdata1_wr = c[8];
    dmi_wdata = wd; sbdata_read = rd;
    @(posedge CLK); #1;
    clear_inputs();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int edges;
    clear_inputs();
    RST = 1'b1;

    // sbcs field layout: ver=0x20000000, busy=0x200000, busyerr=0x400000, readonaddr=0x100000,
    // access<<17, autoinc=0x10000, readondata=0x8000, err<<12, asize 64 -> 0x800, low 0xF.
    // Single 64-bit read on address write, engine answers 2 cycles after the pulse.
    vq.push_back(mkv(C_CS, 32'h0016_0000, 64'h0, 32'h2016_080F, 2'b00, 64'h0, 64'h0));
    vq.push_back(mkv(C_A0, 32'h8000_0000, 64'h0, 32'h2036_080F, 2'b10, 64'h8000_0000, 64'h0));
    vq.push_back(mkv(9'h0, 32'h0, 64'h0, 32'h2036_080F, 2'b00, 64'h8000_0000, 64'h0));
    vq.push_back(mkv(9'h0, 32'h0, 64'h0, 32'h2036_080F, 2'b00, 64'h8000_0000, 64'h0));
    vq.push_back(mkv(C_RR, 32'h0, 64'h1122334455667788, 32'h2016_080F, 2'b00, 64'h8000_0000, 64'h1122334455667788));
    // Three autoincrementing 32-bit writes from 0x100.
    vq.push_back(mkv(C_CS, 32'h0005_0000, 64'h0, 32'h2005_080F, 2'b00, 64'h8000_0000, 64'h1122334455667788));
    vq.push_back(mkv(C_A0, 32'h0000_0100, 64'h0, 32'h2005_080F, 2'b00, 64'h100, 64'h1122334455667788));
    vq.push_back(mkv(C_D0, 32'hA0A0_0001, 64'h0, 32'h2025_080F, 2'b01, 64'h100, 64'h11223344_A0A00001));
    vq.push_back(mkv(9'h0, 32'h0, 64'h0, 32'h2025_080F, 2'b00, 64'h100, 64'h11223344_A0A00001));
    vq.push_back(mkv(C_WR, 32'h0, 64'h0, 32'h2005_080F, 2'b00, 64'h104, 64'h11223344_A0A00001));
    vq.push_back(mkv(C_D0, 32'hA0A0_0002, 64'h0, 32'h2025_080F, 2'b01, 64'h104, 64'h11223344_A0A00002));
    vq.push_back(mkv(9'h0, 32'h0, 64'h0, 32'h2025_080F, 2'b00, 64'h104, 64'h11223344_A0A00002));
    vq.push_back(mkv(C_WR, 32'h0, 64'h0, 32'h2005_080F, 2'b00, 64'h108, 64'h11223344_A0A00002));
    vq.push_back(mkv(C_D0, 32'hA0A0_0003, 64'h0, 32'h2025_080F, 2'b01, 64'h108, 64'h11223344_A0A00003));
    vq.push_back(mkv(9'h0, 32'h0, 64'h0, 32'h2025_080F, 2'b00, 64'h108, 64'h11223344_A0A00003));
    vq.push_back(mkv(C_WR, 32'h0, 64'h0, 32'h2005_080F, 2'b00, 64'h10C, 64'h11223344_A0A00003));
    // Misaligned write: alignment error, no pulse, then W1C clear.
    vq.push_back(mkv(C_A0, 32'h0000_0102, 64'h0, 32'h2005_080F, 2'b00, 64'h102, 64'h11223344_A0A00003));
    vq.push_back(mkv(C_D0, 32'hBBBB_0000, 64'h0, 32'h2005_380F, 2'b00, 64'h102, 64'h11223344_BBBB0000));
    vq.push_back(mkv(C_CS, 32'h0005_7000, 64'h0, 32'h2005_080F, 2'b00, 64'h102, 64'h11223344_BBBB0000));
    // Busy violation during WR_WAIT, suppressed trigger, clear, then normal write.
    vq.push_back(mkv(C_A0, 32'h0000_0200, 64'h0, 32'h2005_080F, 2'b00, 64'h200, 64'h11223344_BBBB0000));
    vq.push_back(mkv(C_D0, 32'hC000_0001, 64'h0, 32'h2025_080F, 2'b01, 64'h200, 64'h11223344_C0000001));
    vq.push_back(mkv(9'h0, 32'h0, 64'h0, 32'h2025_080F, 2'b00, 64'h200, 64'h11223344_C0000001));
    vq.push_back(mkv(C_D0, 32'hC000_0002, 64'h0, 32'h2065_080F, 2'b00, 64'h200, 64'h11223344_C0000001));
    vq.push_back(mkv(C_WR, 32'h0, 64'h0, 32'h2045_080F, 2'b00, 64'h204, 64'h11223344_C0000001));
    vq.push_back(mkv(C_D0, 32'hC000_0003, 64'h0, 32'h2045_080F, 2'b00, 64'h204, 64'h11223344_C0000003));
    vq.push_back(mkv(C_CS, 32'h0045_0000, 64'h0, 32'h2005_080F, 2'b00, 64'h204, 64'h11223344_C0000003));
    vq.push_back(mkv(C_D0, 32'hC000_0004, 64'h0, 32'h2025_080F, 2'b01, 64'h204, 64'h11223344_C0000004));
    vq.push_back(mkv(9'h0, 32'h0, 64'h0, 32'h2025_080F, 2'b00, 64'h204, 64'h11223344_C0000004));
    vq.push_back(mkv(C_WR, 32'h0, 64'h0, 32'h2005_080F, 2'b00, 64'h208, 64'h11223344_C0000004));
    // Read on sbdata0 read, 32-bit access zero-extends engine data.
    vq.push_back(mkv(C_CS, 32'h0004_8000, 64'h0, 32'h2004_880F, 2'b00, 64'h208, 64'h11223344_C0000004));
    vq.push_back(mkv(C_RD, 32'h0, 64'h0, 32'h2024_880F, 2'b10, 64'h208, 64'h11223344_C0000004));
    vq.push_back(mkv(9'h0, 32'h0, 64'h0, 32'h2024_880F, 2'b00, 64'h208, 64'h11223344_C0000004));
    vq.push_back(mkv(C_RR, 32'h0, 64'hCAFEF00D_12345678, 32'h2004_880F, 2'b00, 64'h208, 64'h00000000_12345678));
    // Upper halves of data and address.
    vq.push_back(mkv(C_D1, 32'h55AA_55AA, 64'h0, 32'h2004_880F, 2'b00, 64'h208, 64'h55AA55AA_12345678));
    vq.push_back(mkv(C_A1, 32'h0000_0001, 64'h0, 32'h2004_880F, 2'b00, 64'h1_0000_0208, 64'h55AA55AA_12345678));
    vq.push_back(mkv(C_A1, 32'h0000_0000, 64'h0, 32'h2004_880F, 2'b00, 64'h208, 64'h55AA55AA_12345678));

    repeat (3) @(posedge CLK);
    #1;
    chk("reset sbcs", 64'(sbcs), 64'h2004_080F);
    chk("reset sbaddress", sbaddress, 64'h0);
    chk("reset sbdata", sbdata, 64'h0);
    chk("reset sb_access", 64'(sb_access), 64'd2);
    chk("reset pulses", 64'({start_single_read, start_single_write}), 64'd0);
    RST = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].ctl, vq[i].wd, vq[i].rd);
      chk($sformatf("row%0d sbcs", i), 64'(sbcs), 64'(vq[i].e_sbcs));
      chk($sformatf("row%0d pulse", i), 64'({start_single_read, start_single_write}), 64'(vq[i].e_pulse));
      chk($sformatf("row%0d sbaddress", i), sbaddress, vq[i].e_addr);
      chk($sformatf("row%0d sbdata", i), sbdata, vq[i].e_data);
      if (i == 1) chk("read sb_access", 64'(sb_access), 64'd3);
    end

    // Timeout: engine never answers, WAIT lasts 8 cycles, late ready ignored.
    drive(C_CS, 32'h0005_0000, 64'h0);
    chk("to sbcs setup", 64'(sbcs), 64'h2005_080F);
    drive(C_D0, 32'h0000_0001, 64'h0);
    chk("to pulse", 64'({start_single_read, start_single_write}), 64'd1);
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      drive(9'h0, 32'h0, 64'h0);
      if (!sbcs[21]) begin
        edges = k;
        break;
      end
    end
    chk("to edges to idle", 64'(edges), 64'd9);
    chk("to sbcs", 64'(sbcs), 64'h2005_180F);
    drive(C_WR, 32'h0, 64'h0);
    chk("to late ready sbcs", 64'(sbcs), 64'h2005_180F);
    chk("to late ready addr", sbaddress, 64'h208);
    chk("to late ready pulse", 64'({start_single_read, start_single_write}), 64'd0);
    drive(C_D0, 32'h0000_0002, 64'h0);
    chk("to gated pulse", 64'({start_single_read, start_single_write}), 64'd0);
    chk("to gated data", sbdata, 64'h55AA55AA_00000002);
    drive(C_CS, 32'h0005_7000, 64'h0);
    chk("to clear sbcs", 64'(sbcs), 64'h2005_080F);

    // Bus error read, size change in flight, error clear colliding with completion.
    drive(C_CS, 32'h0015_0000, 64'h0);
    chk("be sbcs setup", 64'(sbcs), 64'h2015_080F);
    drive(C_A0, 32'h0000_0300, 64'h0);
    chk("be pulse", 64'({start_single_read, start_single_write}), 64'd2);
    drive(C_CS, 32'h0011_0000, 64'h0);
    chk("be sbcs in flight", 64'(sbcs), 64'h2031_080F);
    chk("be sb_access held", 64'(sb_access), 64'd2);
    drive(C_RR | C_BE | C_CS, 32'h0011_7000, 64'h0000_DEAD);
    chk("be sbcs", 64'(sbcs), 64'h2011_280F);
    chk("be sbdata kept", sbdata, 64'h55AA55AA_00000002);
    chk("be no autoinc", sbaddress, 64'h300);
    drive(C_CS, 32'h0015_7000, 64'h0);
    chk("be clear sbcs", 64'(sbcs), 64'h2015_080F);

    // Reset in RD_WAIT, engine response arriving across and after reset.
    drive(C_A0, 32'h0000_0400, 64'h0);
    chk("rst pulse", 64'({start_single_read, start_single_write}), 64'd2);
    drive(9'h0, 32'h0, 64'h0);
    chk("rst busy before", 64'(sbcs[21]), 64'd1);
    #1;
    RST = 1'b1;
    read_data_ready = 1'b1;
    sbdata_read = 64'h99;
    #1;
    chk("rst async sbcs", 64'(sbcs), 64'h2004_080F);
    chk("rst async addr", sbaddress, 64'h0);
    chk("rst async data", sbdata, 64'h0);
    chk("rst async sb_access", 64'(sb_access), 64'd2);
    chk("rst async pulses", 64'({start_single_read, start_single_write}), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("post rst sbcs", 64'(sbcs), 64'h2004_080F);
    chk("post rst data", sbdata, 64'h0);
    read_data_ready = 1'b0;
    sbdata_read = 64'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("post rst pulses%0d", k), 64'({start_single_read, start_single_write}), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sba_ctrl.md
Name: sba_ctrl

Overview:
- Debug-module System Bus Access (SBA) sequencer implementing the RISC-V Debug Spec 0.13 sbcs semantics.
- Owns the sbcs, sbaddress and sbdata registers; decodes DMI register accesses from the debug module.
- Issues single-beat start pulses to the SBA AXI master engine and collects its completion and error responses.
- Sits between the DM register file and bus_access.

Parameters:
SBASIZE, 64, system bus address width; reported in sbcs.sbasize.
TIMEOUT, 1023, max cycles waiting for engine completion before sberror=1; 0 disables.

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
sbcs_wr  in  1  DMI write strobe, sbcs (0x38)
sbaddr0_wr  in  1  DMI write strobe, sbaddress0 (0x39)
sbaddr1_wr  in  1  DMI write strobe, sbaddress1 (0x3A)
sbdata0_wr  in  1  DMI write strobe, sbdata0 (0x3C)
sbdata1_wr  in  1  DMI write strobe, sbdata1 (0x3D)
sbdata0_rd  in  1  DMI read strobe, sbdata0 (value sampled same cycle)
dmi_wdata  in  32  DMI write data
sbcs  out  32  sbcs readback
sbaddress  out  SBASIZE  current address to engine and DMI readback
sbdata  out  64  {sbdata1,sbdata0}; write data to engine and DMI readback
sb_access  out  3  access size code (0=8b, 1=16b, 2=32b, 3=64b) to engine
start_single_read  out  1  one-cycle read start pulse
start_single_write  out  1  one-cycle write start pulse
read_data_ready  in  1  engine read complete, data valid
write_data_ready  in  1  engine write complete
sbdata_read  in  64  engine read data
bus_error  in  1  engine error response, qualifies either ready

Behaviour:
Reset:
- sbaddress=0, sbdata=0, start_single_* = 0, state=IDLE.
- All RW sbcs fields = 0; sb_access=2 (reset value of the sbaccess field).
sbcs layout:
- [31:29] sbversion=1; [28:23]=0; [22] sbbusyerror; [21] sbbusy=(state!=IDLE); [20] sbreadonaddr; [19:17] sbaccess; [16] sbautoincrement; [15] sbreadondata; [14:12] sberror; [11:5] sbasize=SBASIZE; [4:0]=5'b01111.
sbcs write:
- RW fields are taken from dmi_wdata.
- sbbusyerror is write-1-to-clear; sberror is write-1-to-clear per bit.
- An sbcs write is accepted while busy, but a changed sbaccess does not affect the access in flight.
Busy violation:
- Any of sbaddr0_wr, sbaddr1_wr, sbdata0_wr, sbdata1_wr or sbdata0_rd while sbbusy=1 sets sbbusyerror.
- The write is discarded; no access is started.
Start gating:
- An access starts only if sberror==0 && sbbusyerror==0; otherwise the trigger is silently ignored.
Triggers (from IDLE):
- sbaddr0_wr with sbreadonaddr=1 → read.
- sbdata0_wr → write.
- sbdata0_rd with sbreadondata=1 → read; the DMI sees the old sbdata, and the new read is launched the next cycle.
Pre-checks at trigger (the access does not start, error is set instead):
- sbaccess>3 → sberror=4.
- sbaddress not aligned to 2^sbaccess → sberror=3.
FSM:
- IDLE→RD_REQ or WR_REQ: start pulse asserted exactly 1 cycle → RD_WAIT or WR_WAIT.
- WAIT→IDLE when the matching ready is seen (any cycle ≥1 after the pulse).
- On read ready with bus_error=0: sbdata ← sbdata_read (zero-extend low 2^sbaccess bytes).
- On ready with bus_error=1: sberror=2; sbdata unchanged; no increment.
- WAIT timeout: a counter counts cycles in WAIT; at TIMEOUT → IDLE, sberror=1; a late ready is ignored.
- Trigger-to-IDLE latency with a ready arriving 1 cycle after the pulse: 3 cycles.
Autoincrement:
- On successful completion with sbautoincrement=1: sbaddress += (1<<sbaccess), modulo 2^SBASIZE; wraps silently.
Register writes:
- sbaddr0_wr loads sbaddress[31:0]; sbaddr1_wr loads sbaddress[63:32] (ignored if SBASIZE≤32).
- sbdata0_wr / sbdata1_wr load the respective halves; on sbdata0_wr, sbdata0 is updated before the write start.
Simultaneous events:
- A ready and an sbcs error-clear in the same cycle: the new error wins.
- Reset mid-access: immediate return to IDLE with no pulses; engine responses arriving after reset are ignored.

Decomposition:
- Package sba_pkg holds:
  - DMI address constants 0x38–0x3D;
  - sbcs bit-position constants;
  - sberror codes NONE=0, TIMEOUT=1, BADADDR=2, ALIGN=3, SIZE=4;
  - FSM state encoding IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- No sub-module needed; the timeout counter stays inline.

Test Plan:
- sbcs=sbreadonaddr|sbaccess=3, write sbaddr0=0x8000_0000, engine returns 0x1122334455667788 after 2 cycles → one start_single_read pulse; sbdata=0x1122334455667788; sbbusy 1 then 0.
- sbaccess=2, autoinc=1, sbaddr0=0x100, three sbdata0_wr → three start_single_write pulses at 0x100, 0x104, 0x108; final sbaddress=0x10C.
- sbaccess=2, sbaddr0=0x102, then sbdata0_wr → no pulse; sberror=3; write sbcs with [14:12]=3'b111 → sberror=0.
- sbdata0_wr, then sbdata0_wr again during WR_WAIT → sbbusyerror=1; second write ignored; the next trigger is suppressed until sbbusyerror is cleared.
- TIMEOUT=8, engine never responds → sberror=1 and IDLE after 8 WAIT cycles; a ready at cycle 10 changes nothing.
- Read with bus_error=1 → sberror=2, sbdata unchanged; assert RST during RD_WAIT → sbcs RW fields 0, sb_access=2, no pulses.
